// File: rtl/program_sequencer.sv
// Instruction fetch/dispatch sequencer feeding control_unit over the run/done handshake.
// Optional EXEC watchdog with FAULT state is built when SEQ_WATCHDOG_EN is defined.
module program_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int WDT_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instruction,
    output logic              run,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);

`ifdef SEQ_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED, S_FAULT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED
    } state_t;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [15:0]       instr_next;
    logic [15:0]       count_next;

    if (WDT_LIMIT < 1) begin : g_bad_wdt_limit
        $error("program_sequencer: WDT_LIMIT must be at least 1");
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_expired;

    assign wdt_expired = (wdt_cnt == WDT_W'(WDT_LIMIT - 1));
`endif

    assign mem_addr = pc;
    assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted   = (state == S_HALTED);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instruction;
        count_next = instr_count;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    count_next = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                instr_next = mem_rdata;
                case (mem_rdata[1:0])
                    2'b10: begin
                        pc_next    = mem_rdata[ADDR_W+7:8];
                        state_next = S_FETCH;
                    end
                    2'b11:   state_next = S_HALTED;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (done) begin
                    pc_next    = pc + ADDR_W'(1);
                    count_next = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;
                    state_next = S_FETCH;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wdt_expired) begin
                    state_next = S_FAULT;
                end
`endif
            end
`ifdef SEQ_WATCHDOG_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= 16'h0000;
            instr_count <= 16'h0000;
            run         <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instruction <= instr_next;
            instr_count <= count_next;
            // run is a registered copy of "next cycle is EXEC", so it drops the cycle after done
            run         <= (state_next == S_EXEC);
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_cnt <= '0;
            error   <= 1'b0;
        end else begin
            if (state != S_EXEC)
                wdt_cnt <= '0;
            else if (!done && !wdt_expired)
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            error <= (state_next == S_FAULT);
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetches 16-bit instructions from a synchronous instruction ROM and drives them into the processor `control_unit` one at a time. It handles the `run`/`done` handshake with the control unit, the program counter, jumps and halt. It sits between the instruction memory and `control_unit`; its `instruction` and `run` outputs connect directly to the matching `control_unit` inputs.

## Interface
- `ADDR_W`, 4: program counter / ROM address width (program length 2^ADDR_W words).
- `WDT_LIMIT`, 8: watchdog limit in EXEC cycles (used only with `SEQ_WATCHDOG_EN`).
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset. Must also drive `control_unit.reset`.
- `start`  in  1: single-cycle request to begin a program at address 0. Honoured only in IDLE or HALTED.
- `mem_addr`  out  ADDR_W: ROM read address. Combinationally equal to the PC.
- `mem_rdata`  in  16: ROM data. Valid one cycle after `mem_addr` is presented.
- `instruction`  out  16: registered instruction to `control_unit`. Stable for the whole EXEC period.
- `run`  out  1: registered. High only in EXEC.
- `done`  in  1: from `control_unit`. Marks its STORE cycle.
- `busy`  out  1: high in FETCH, DECODE and EXEC.
- `halted`  out  1: high in HALTED.
- `error`  out  1: watchdog fault flag.
- `instr_count`  out  16: count of R/I instructions retired. Saturates at 16'hFFFF.

## Operation
- Instruction classes use `instruction[1:0]`:
  - 2'b00 R-type and 2'b01 I-type are executed by `control_unit`.
  - 2'b10 JMP is handled internally; target is `instruction[ADDR_W+7:8]`.
  - 2'b11 HALT is handled internally.
- States: IDLE, FETCH, DECODE, EXEC, HALTED, FAULT (FAULT exists only with the macro).
- IDLE: `start`=1 → PC<=0, `instr_count`<=0, go to FETCH.
- FETCH: `mem_addr`=PC; unconditionally go to DECODE.
- DECODE: `mem_rdata` is captured into `instruction`, then:
  - format 00/01 → EXEC;
  - format 10 → PC<=target, go to FETCH (not counted, `run` stays low);
  - format 11 → HALTED.
- EXEC: `run`=1.
  - On `done`=1: PC<=PC+1 (wraps from 2^ADDR_W-1 to 0), `instr_count`<=`instr_count`+1 (saturating), go to FETCH.
  - `run` is low in the cycle after `done`, so `control_unit` parks in its INITIAL state.
- HALTED: hold all registers. `start`=1 → same action as from IDLE.
- `start` outside IDLE/HALTED is ignored, with no effect on the PC or counter.
- `done` outside EXEC is ignored.
- JMP to the current address is legal and forms an infinite fetch loop; it runs until reset.

## Timing
- Reset values: state=IDLE, PC=0, `mem_addr`=0, `instruction`=16'h0000, `run`=0, `busy`=0, `halted`=0, `error`=0, `instr_count`=0.
- Reset mid-EXEC clears the sequencer immediately, independent of the clock. `control_unit` clears on the next edge.
- Cycle timing from `start` sampled high at edge 0:
  - FETCH is cycle 1;
  - DECODE is cycle 2;
  - EXEC begins cycle 3 with `run`=1;
  - `done` arrives in cycle 6 (4th `run` cycle);
  - FETCH of the next instruction is cycle 7.
- Per-instruction cost: R/I instruction 6 cycles; JMP 2 cycles; HALT 2 cycles to reach `halted`=1.
- `instruction` changes only at the DECODE→next edge, so it is stable through the `control_unit` STORE cycle.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - a counter clears on EXEC entry and increments each EXEC cycle without `done`;
  - when it reaches `WDT_LIMIT`: `run`<=0, `error`<=1, go to FAULT;
  - FAULT holds until reset; `start` is ignored there.
- `SEQ_WATCHDOG_EN` undefined: EXEC waits indefinitely, `error` is tied to 0, and no FAULT state or counter is built.

## Test plan
- ROM[0]=R-type 16'h2400, ROM[1]=HALT 16'h0003; pulse `start` → `run` high cycles 3–6, `instr_count`=1, `halted`=1 at cycle 9, `mem_addr`=1.
- ROM[0]=JMP to 5 (16'h0502), ROM[5]=I-type, ROM[6]=HALT → addresses 1–4 never fetched, `instr_count`=1, `halted` set.
- ROM filled with R-type except ROM[15]=JMP to 0; run 40 instructions → PC wraps via jump, `instr_count`=40, `run` never high in JMP cycles.
- Assert `reset` for 1 cycle mid-EXEC (cycle 4) → all outputs at reset values asynchronously; a later `start` restarts from address 0.
- `start` pulsed during EXEC → ignored, PC/count unchanged; `start` while HALTED → restarts at 0, `instr_count` back to 0.
- With `SEQ_WATCHDOG_EN`, hold `done`=0 in EXEC → `error`=1 and `run`=0 after 8 EXEC cycles, FAULT held until reset. Without the macro → `run` stays high indefinitely, `error`=0.
